// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply sequencer.
package hilo_pkg;
    localparam int WAIT_MAX_DEF = 8;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_MTHI  = 2'd2;
    localparam logic [1:0] OP_MTLO  = 2'd3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FIX   = 2'd3;
endpackage

// File: rtl/umul_fix.sv
// Converts the high word of a signed 32x32 product into the unsigned high word.
// Purely combinational; no flow control.
module umul_fix (
    input  logic [31:0] prod_hi,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] hi_u
);
    // A set sign bit was weighted -2^31 instead of +2^31; add the other operand back per set bit.
    assign hi_u = prod_hi + (op1[31] ? op2 : 32'd0) + (op2[31] ? op1 : 32'd0);
endmodule

// File: rtl/hilo_mul_ctrl.sv
// Sequences MULT/MULTU through the 2-cycle multiplier and owns HI/LO.
// Latency: MULT 3 cycles, MULTU 4 cycles, MTHI/MTLO 1 cycle to visible HI/LO.
// Backpressure: req_ready low while an op is in flight or flush is high.
module hilo_mul_ctrl
    import hilo_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF,
    parameter int OP_W     = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    input  logic [OP_W-1:0] req_op,
    input  logic [31:0]     req_src1,
    input  logic [31:0]     req_src2,
    output logic            req_ready,
    input  logic            flush,
    output logic            mul_begin,
    output logic [31:0]     mul_op1,
    output logic [31:0]     mul_op2,
    input  logic [63:0]     mul_product,
    input  logic            mul_end,
    output logic [31:0]     hi,
    output logic [31:0]     lo,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam int CNT_W = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      op1_q, op1_d, op2_q, op2_d;
    logic             uns_q, uns_d;
    logic [63:0]      prod_q, prod_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic             err_q, err_d;
    logic             done_c;
    logic [31:0]      hi_u;

    umul_fix u_fix (
        .prod_hi (prod_q[63:32]),
        .op1     (op1_q),
        .op2     (op2_q),
        .hi_u    (hi_u)
    );

    assign req_ready = (state_q == S_IDLE) & ~flush;
    assign mul_begin = (state_q == S_ISSUE) & ~flush;
    assign busy      = (state_q != S_IDLE);
    assign mul_op1   = op1_q;
    assign mul_op2   = op2_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign err       = err_q;
    assign done      = done_c;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        uns_d   = uns_q;
        prod_d  = prod_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;
        done_c  = 1'b0;
        // Flush overrides every write and transition, including a coincident end pulse.
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        case (req_op)
                            OP_MULT, OP_MULTU: begin
                                op1_d   = req_src1;
                                op2_d   = req_src2;
                                uns_d   = (req_op == OP_MULTU);
                                state_d = S_ISSUE;
                            end
                            OP_MTHI: hi_d = req_src1;
                            default: lo_d = req_src1;
                        endcase
                    end
                end
                S_ISSUE: begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
                S_WAIT: begin
                    if (mul_end) begin
                        prod_d = mul_product;
                        if (uns_q) begin
                            state_d = S_FIX;
                        end else begin
                            hi_d    = mul_product[63:32];
                            lo_d    = mul_product[31:0];
                            done_c  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    lo_d    = prod_q[31:0];
                    hi_d    = hi_u;
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            uns_q   <= 1'b0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            uns_q   <= uns_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Directed bench for hilo_mul_ctrl with a registered signed multiplier model.
module tb_hilo_mul_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_src1, req_src2;
    logic        req_ready;
    logic        flush;
    logic        mul_begin;
    logic [31:0] mul_op1, mul_op2;
    logic [63:0] mul_product;
    logic        mul_end;
    logic [31:0] hi, lo;
    logic        busy, done, err;
    logic        m_en;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hilo_mul_ctrl #(.WAIT_MAX(8), .OP_W(2)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_src1    (req_src1),
        .req_src2    (req_src2),
        .req_ready   (req_ready),
        .flush       (flush),
        .mul_begin   (mul_begin),
        .mul_op1     (mul_op1),
        .mul_op2     (mul_op2),
        .mul_product (mul_product),
        .mul_end     (mul_end),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // Multiplier: end pulse and signed product one cycle after begin.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mul_end     <= 1'b0;
            mul_product <= '0;
        end else begin
            mul_end     <= mul_begin & m_en;
            mul_product <= 64'($signed(mul_op1) * $signed(mul_op2));
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_op = 2'd0;
        req_src1 = '0; req_src2 = '0; flush = 1'b0; m_en = 1'b1;
        #3;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_begin", mul_begin, 0);
        chk("rst_done", done, 0);
        chk("rst_op1", mul_op1, 0);
        tick(); tick();
        resetn = 1'b1;
        tick();

        // MULT -1 x 2
        req(2'd0, 32'hFFFF_FFFF, 32'h2); #1;
        chk("mult_ready", req_ready, 1);
        tick(); req_valid = 1'b0; #1;
        chk("mult_c1_begin", mul_begin, 1);
        chk("mult_c1_busy", busy, 1);
        chk("mult_c1_op1", mul_op1, 32'hFFFF_FFFF);
        tick(); #1;
        chk("mult_c2_done", done, 1);
        chk("mult_c2_busy", busy, 1);
        chk("mult_c2_begin", mul_begin, 0);
        tick(); #1;
        chk("mult_c3_hi", hi, 32'hFFFF_FFFF);
        chk("mult_c3_lo", lo, 32'hFFFF_FFFE);
        chk("mult_c3_busy", busy, 0);
        chk("mult_c3_done", done, 0);

        // MULTU 0xFFFFFFFF x 2
        req(2'd1, 32'hFFFF_FFFF, 32'h2);
        tick(); req_valid = 1'b0;
        tick(); #1;
        chk("multu_c2_done", done, 0);
        tick(); #1;
        chk("multu_c3_done", done, 1);
        chk("multu_c3_busy", busy, 1);
        tick(); #1;
        chk("multu_c4_hi", hi, 32'h1);
        chk("multu_c4_lo", lo, 32'hFFFF_FFFE);
        chk("multu_c4_busy", busy, 0);

        // MULTU 0x80000000 x 0x80000000
        req(2'd1, 32'h8000_0000, 32'h8000_0000);
        tick(); req_valid = 1'b0;
        tick(); tick(); tick(); #1;
        chk("multu2_hi", hi, 32'h4000_0000);
        chk("multu2_lo", lo, 32'h0);

        // MTHI then MTLO back to back
        req(2'd2, 32'h1234_5678, 32'h0); #1;
        chk("mthi_ready", req_ready, 1);
        tick();
        req(2'd3, 32'h9ABC_DEF0, 32'h0); #1;
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_busy", busy, 0);
        chk("mtlo_ready", req_ready, 1);
        tick(); req_valid = 1'b0; #1;
        chk("mtlo_lo", lo, 32'h9ABC_DEF0);
        chk("mtlo_hi_kept", hi, 32'h1234_5678);
        chk("mtlo_busy", busy, 0);

        // MULT 3 x 5 flushed in WAIT together with mul_end
        req(2'd0, 32'd3, 32'd5);
        tick(); req_valid = 1'b0;
        tick(); flush = 1'b1; #1;
        chk("flush_end_seen", mul_end, 1);
        chk("flush_done", done, 0);
        chk("flush_ready", req_ready, 0);
        tick(); flush = 1'b0; #1;
        chk("flush_hi", hi, 32'h1234_5678);
        chk("flush_lo", lo, 32'h9ABC_DEF0);
        chk("flush_busy", busy, 0);
        req(2'd0, 32'd7, 32'd6);
        tick(); req_valid = 1'b0;
        tick(); tick(); #1;
        chk("mult76_lo", lo, 32'd42);
        chk("mult76_hi", hi, 32'd0);

        // Watchdog: multiplier never answers
        m_en = 1'b0;
        req(2'd0, 32'd9, 32'd9);
        tick(); req_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        #1;
        chk("wd_c9_busy", busy, 1);
        chk("wd_c9_err", err, 0);
        tick(); #1;
        chk("wd_err", err, 1);
        chk("wd_busy", busy, 0);
        chk("wd_lo", lo, 32'd42);
        chk("wd_ready", req_ready, 1);
        m_en = 1'b1;
        req(2'd3, 32'h55, 32'h0);
        tick(); req_valid = 1'b0; #1;
        chk("wd_after_lo", lo, 32'h55);
        chk("wd_err_sticky", err, 1);

        // Async reset during FIX
        req(2'd1, 32'd3, 32'd4);
        tick(); req_valid = 1'b0;
        tick(); tick(); #1;
        chk("rstfix_done_pre", done, 1);
        resetn = 1'b0; #1;
        chk("rstfix_hi", hi, 0);
        chk("rstfix_lo", lo, 0);
        chk("rstfix_busy", busy, 0);
        chk("rstfix_err", err, 0);
        chk("rstfix_done", done, 0);
        tick();
        resetn = 1'b1;
        tick(); #1;
        chk("rstfix_lo_after", lo, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
